branch_predictor: RTL and testbench



---
 rtl/branch_predictor_if.sv | 35 +++
 rtl/branch_predictor.sv | 98 +++++++++
 tb/tb_branch_predictor.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup, ID jump / EX branch resolution bundle for branch_predictor.
// slave = predictor side, master = pipeline (or bench) side.
interface branch_predictor_if;
  logic [15:0] pc_if;
  logic        pred_taken;
  logic [15:0] pred_next_pc;
  logic        id_valid;
  logic [15:0] id_pc;
  logic [15:0] id_target;
  logic        id_pred_taken;
  logic [15:0] id_pred_pc;
  logic        ex_valid;
  logic [15:0] ex_pc;
  logic        ex_taken;
  logic [15:0] ex_target;
  logic        ex_pred_taken;
  logic [15:0] ex_pred_pc;
  logic        id_stall;
  logic        jump_miss;
  logic        branch_miss;
  logic [15:0] correct_pc;
  logic [15:0] miss_count;

  modport slave (
    input  pc_if, id_valid, id_pc, id_target, id_pred_taken, id_pred_pc,
           ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_pc, id_stall,
    output pred_taken, pred_next_pc, jump_miss, branch_miss, correct_pc, miss_count
  );

  modport master (
    output pc_if, id_valid, id_pc, id_target, id_pred_taken, id_pred_pc,
           ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_pc, id_stall,
    input  pred_taken, pred_next_pc, jump_miss, branch_miss, correct_pc, miss_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency next-PC lookup, ID jump / EX branch
// miss detection with redirect PC, table updates on the resolving edge, saturating miss counter.
module branch_predictor #(
  parameter int IDX_BITS = 4,
  parameter bit ENABLE   = 1'b1
) (
  input logic clk,
  input logic reset,
  branch_predictor_if.slave bp
);
  localparam int N  = 1 << IDX_BITS;
  localparam int TW = 16 - IDX_BITS;

  logic          r_valid  [N];
  logic [TW-1:0] r_tag    [N];
  logic [15:0]   r_target [N];
  logic [1:0]    r_ctr    [N];
  logic [15:0]   r_miss_count;

  logic [IDX_BITS-1:0] w_if_idx, w_ex_idx, w_id_idx;
  logic w_if_hit, w_ex_hit, w_pred_taken;
  logic w_ex_pred_taken, w_branch_miss, w_jump_go, w_jump_miss;
  logic w_br_wr, w_jp_wr;
  logic [15:0] w_correct_pc;

  assign w_if_idx = bp.pc_if[IDX_BITS-1:0];
  assign w_ex_idx = bp.ex_pc[IDX_BITS-1:0];
  assign w_id_idx = bp.id_pc[IDX_BITS-1:0];

  assign w_if_hit     = r_valid[w_if_idx] && (r_tag[w_if_idx] == bp.pc_if[15:IDX_BITS]);
  assign w_ex_hit     = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == bp.ex_pc[15:IDX_BITS]);
  assign w_pred_taken = ENABLE && w_if_hit && r_ctr[w_if_idx][1];

  assign bp.pred_taken   = w_pred_taken;
  assign bp.pred_next_pc = w_pred_taken ? r_target[w_if_idx] : bp.pc_if + 16'd1;

  // With prediction disabled nothing was ever predicted taken.
  assign w_ex_pred_taken = ENABLE ? bp.ex_pred_taken : 1'b0;
  assign w_branch_miss   = bp.ex_valid &&
                           ((bp.ex_taken != w_ex_pred_taken) ||
                            (bp.ex_taken && (bp.ex_pred_pc != bp.ex_target)));

  // An EX redirect squashes the ID jump as wrong-path.
  assign w_jump_go   = bp.id_valid && !bp.id_stall && !w_branch_miss;
  assign w_jump_miss = w_jump_go &&
                       (!ENABLE || !bp.id_pred_taken || (bp.id_pred_pc != bp.id_target));

  always_comb begin
    w_correct_pc = 16'h0000;
    if (w_branch_miss)
      w_correct_pc = bp.ex_taken ? bp.ex_target : bp.ex_pc + 16'd1;
    else if (w_jump_miss)
      w_correct_pc = bp.id_target;
  end

  assign bp.branch_miss = w_branch_miss;
  assign bp.jump_miss   = w_jump_miss;
  assign bp.correct_pc  = w_correct_pc;
  assign bp.miss_count  = r_miss_count;

  // A not-taken branch that misses the table writes nothing, so it cannot block a jump.
  assign w_br_wr = ENABLE && bp.ex_valid && (w_ex_hit || bp.ex_taken);
  assign w_jp_wr = ENABLE && w_jump_go && !(w_br_wr && (w_id_idx == w_ex_idx));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= 16'h0000;
        r_ctr[i]    <= 2'd1;
      end
      r_miss_count <= 16'h0000;
    end else begin
      if (w_br_wr) begin
        if (w_ex_hit && bp.ex_taken) begin
          if (r_ctr[w_ex_idx] != 2'd3) r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
          r_target[w_ex_idx] <= bp.ex_target;
        end else if (w_ex_hit) begin
          if (r_ctr[w_ex_idx] != 2'd0) r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
        end else begin
          r_valid[w_ex_idx]  <= 1'b1;
          r_tag[w_ex_idx]    <= bp.ex_pc[15:IDX_BITS];
          r_target[w_ex_idx] <= bp.ex_target;
          r_ctr[w_ex_idx]    <= 2'd2;
        end
      end
      if (w_jp_wr) begin
        r_valid[w_id_idx]  <= 1'b1;
        r_tag[w_id_idx]    <= bp.id_pc[15:IDX_BITS];
        r_target[w_id_idx] <= bp.id_target;
        r_ctr[w_id_idx]    <= 2'd3;
      end
      if ((w_branch_miss || w_jump_miss) && (r_miss_count != 16'hFFFF))
        r_miss_count <= r_miss_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (IDX_BITS=4, ENABLE=1).
module tb_branch_predictor;
  logic clk;
  logic reset;
  int total = 0;
  int bad = 0;

  branch_predictor_if bus();

  branch_predictor #(.IDX_BITS(4), .ENABLE(1'b1)) dut (
    .clk(clk),
    .reset(reset),
    .bp(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.id_valid = 1'b0;      bus.id_pc = 16'h0;      bus.id_target = 16'h0;
    bus.id_pred_taken = 1'b0; bus.id_pred_pc = 16'h0; bus.id_stall = 1'b0;
    bus.ex_valid = 1'b0;      bus.ex_pc = 16'h0;      bus.ex_taken = 1'b0;
    bus.ex_target = 16'h0;    bus.ex_pred_taken = 1'b0; bus.ex_pred_pc = 16'h0;
  endtask

  task automatic jump(input logic [15:0] pc, input logic [15:0] tgt,
                      input logic pt, input logic [15:0] ppc, input logic stall);
    bus.id_valid = 1'b1; bus.id_pc = pc; bus.id_target = tgt;
    bus.id_pred_taken = pt; bus.id_pred_pc = ppc; bus.id_stall = stall;
  endtask

  task automatic branch(input logic [15:0] pc, input logic tk, input logic [15:0] tgt,
                        input logic pt, input logic [15:0] ppc);
    bus.ex_valid = 1'b1; bus.ex_pc = pc; bus.ex_taken = tk;
    bus.ex_target = tgt; bus.ex_pred_taken = pt; bus.ex_pred_pc = ppc;
  endtask

  // Commit on the rising edge, then return to the falling edge for the next step.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    bus.pc_if = 16'h0010;
    #1;
    chk("rst_pred_taken", {15'h0, bus.pred_taken}, 16'h0000);
    chk("rst_next_pc", bus.pred_next_pc, 16'h0011);
    chk("rst_miss_count", bus.miss_count, 16'h0000);
    bus.pc_if = 16'hFFFF;
    #1;
    chk("rst_next_wrap", bus.pred_next_pc, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // Unpredicted jump installs a strong entry
    jump(16'h0020, 16'h0050, 1'b0, 16'h0021, 1'b0);
    #1;
    chk("jmp_miss", {15'h0, bus.jump_miss}, 16'h0001);
    chk("jmp_correct_pc", bus.correct_pc, 16'h0050);
    chk("jmp_bmiss", {15'h0, bus.branch_miss}, 16'h0000);
    step();
    idle();
    bus.pc_if = 16'h0020;
    #1;
    chk("jmp_lookup_taken", {15'h0, bus.pred_taken}, 16'h0001);
    chk("jmp_lookup_pc", bus.pred_next_pc, 16'h0050);
    chk("cnt_after_jmp", bus.miss_count, 16'h0001);
    jump(16'h0020, 16'h0050, 1'b1, 16'h0050, 1'b0);
    #1;
    chk("jmp_hit_nomiss", {15'h0, bus.jump_miss}, 16'h0000);
    chk("jmp_hit_cpc", bus.correct_pc, 16'h0000);
    step();
    idle();

    // Branch at 0x0031: allocate (ctr 2), taken (3), not taken (2), not taken (1)
    bus.pc_if = 16'h0031;
    branch(16'h0031, 1'b1, 16'h0040, 1'b0, 16'h0032);
    #1;
    chk("br1_miss", {15'h0, bus.branch_miss}, 16'h0001);
    chk("br1_cpc", bus.correct_pc, 16'h0040);
    step();
    idle();
    #1;
    chk("br1_lookup", bus.pred_next_pc, 16'h0040);
    branch(16'h0031, 1'b1, 16'h0040, 1'b1, 16'h0040);
    #1;
    chk("br2_nomiss", {15'h0, bus.branch_miss}, 16'h0000);
    step();
    branch(16'h0031, 1'b0, 16'h0040, 1'b1, 16'h0040);
    #1;
    chk("br3_miss", {15'h0, bus.branch_miss}, 16'h0001);
    chk("br3_cpc", bus.correct_pc, 16'h0032);
    chk("br3_preupdate_lookup", {15'h0, bus.pred_taken}, 16'h0001);
    step();
    idle();
    #1;
    chk("br3_still_taken", {15'h0, bus.pred_taken}, 16'h0001);
    chk("cnt_after_br3", bus.miss_count, 16'h0003);
    branch(16'h0031, 1'b0, 16'h0040, 1'b1, 16'h0040);
    step();
    idle();
    #1;
    chk("br4_weak_nt", {15'h0, bus.pred_taken}, 16'h0000);
    chk("br4_next_pc", bus.pred_next_pc, 16'h0032);
    chk("cnt_after_br4", bus.miss_count, 16'h0004);

    // Branch miss squashes a same-cycle jump miss
    branch(16'h0045, 1'b1, 16'h0060, 1'b0, 16'h0046);
    jump(16'h0046, 16'h0070, 1'b0, 16'h0047, 1'b0);
    #1;
    chk("both_bmiss", {15'h0, bus.branch_miss}, 16'h0001);
    chk("both_jmiss", {15'h0, bus.jump_miss}, 16'h0000);
    chk("both_cpc", bus.correct_pc, 16'h0060);
    step();
    idle();
    bus.pc_if = 16'h0046;
    #1;
    chk("both_no_jmp_update", {15'h0, bus.pred_taken}, 16'h0000);
    chk("both_cnt", bus.miss_count, 16'h0005);
    bus.pc_if = 16'h0045;
    #1;
    chk("both_br_alloc", bus.pred_next_pc, 16'h0060);

    // Stalled jump is ignored until released
    bus.pc_if = 16'h0087;
    jump(16'h0087, 16'h0090, 1'b0, 16'h0088, 1'b1);
    #1;
    chk("stall_jmiss", {15'h0, bus.jump_miss}, 16'h0000);
    step();
    #1;
    chk("stall_no_update", {15'h0, bus.pred_taken}, 16'h0000);
    chk("stall_cnt", bus.miss_count, 16'h0005);
    bus.id_stall = 1'b0;
    #1;
    chk("unstall_jmiss", {15'h0, bus.jump_miss}, 16'h0001);
    chk("unstall_cpc", bus.correct_pc, 16'h0090);
    step();
    idle();
    #1;
    chk("unstall_lookup", bus.pred_next_pc, 16'h0090);

    // Same index 8: correctly predicted branch allocates, jump update dropped
    branch(16'h0018, 1'b1, 16'h00A0, 1'b1, 16'h00A0);
    jump(16'h0028, 16'h00B0, 1'b0, 16'h0029, 1'b0);
    #1;
    chk("conf_bmiss", {15'h0, bus.branch_miss}, 16'h0000);
    chk("conf_jmiss", {15'h0, bus.jump_miss}, 16'h0001);
    chk("conf_cpc", bus.correct_pc, 16'h00B0);
    step();
    idle();
    bus.pc_if = 16'h0018;
    #1;
    chk("conf_br_wins", bus.pred_next_pc, 16'h00A0);
    bus.pc_if = 16'h0028;
    #1;
    chk("conf_jmp_dropped", {15'h0, bus.pred_taken}, 16'h0000);
    chk("conf_cnt", bus.miss_count, 16'h0007);

    // Saturate the miss counter: 7 + 65528 = 0xFFFF
    bus.pc_if = 16'h00C3;
    branch(16'h00C3, 1'b1, 16'h00D0, 1'b0, 16'h00C4);
    repeat (65527) @(posedge clk);
    @(negedge clk);
    #1;
    chk("sat_minus1", bus.miss_count, 16'hFFFE);
    repeat (9) @(posedge clk);
    @(negedge clk);
    #1;
    chk("sat_hold", bus.miss_count, 16'hFFFF);
    chk("sat_pred_taken", {15'h0, bus.pred_taken}, 16'h0001);

    // Asynchronous reset mid-run
    reset = 1'b1;
    #1;
    chk("arst_cnt", bus.miss_count, 16'h0000);
    chk("arst_pred_taken", {15'h0, bus.pred_taken}, 16'h0000);
    chk("arst_next_pc", bus.pred_next_pc, 16'h00C4);
    chk("arst_bmiss_follows", {15'h0, bus.branch_miss}, 16'h0001);
    step();
    #1;
    chk("arst_cnt_held", bus.miss_count, 16'h0000);
    reset = 1'b0;
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
